mem_arbiter: RTL and testbench

- Shares the single-port synchronous RAM between two requesters: the instruction-fetch port (read-only) and the data port (load/store).
- Sits between the control/fetch logic and RAM. Each requester uses a req/ack handshake; the arbiter owns the RAM address, write-enable and write-data pins.
- One transaction is in flight at a time. Two-way round-robin on contention, or fixed data priority.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_rr2.sv | 37 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM encodings and port IDs.
package mem_arbiter_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned STRB_W  = 4;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way request picker with a registered last-winner pointer.
module arb_rr2
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_d,
  input  logic grant_en,
  output logic winner_c
);

  logic last;

  // Contention goes to data under fixed priority, else to whoever lost last time.
  always_comb begin
    winner_c = PORT_IF;
    if (req_if && req_d) begin
      if (DATA_PRIORITY != 0) winner_c = PORT_D;
      else                    winner_c = (last == PORT_IF) ? PORT_D : PORT_IF;
    end else if (req_d) begin
      winner_c = PORT_D;
    end
  end

  // Pointer starts at data so that fetch wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last <= PORT_D;
    end else if (grant_en && (req_if || req_d)) begin
      last <= winner_c;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the data port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned READ_LAT      = 1,
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic              if_err_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [STRB_W-1:0] d_wstrb_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [STRB_W-1:0] ram_wstrb_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

  logic [STATE_W-1:0] state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               gnt_port, gnt_port_n;
  logic               gnt_we, gnt_we_n;
  logic               winner;
  logic               grant_en;

  logic              if_ack_n, if_err_n, d_ack_n, ram_we_n, busy_n;
  logic [DATA_W-1:0] if_rdata_n, d_rdata_n, ram_wdata_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [STRB_W-1:0] ram_wstrb_n;

  assign grant_en = (state == ARB_IDLE);

  arb_rr2 #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_if  (if_req_i),
    .req_d   (d_req_i),
    .grant_en(grant_en),
    .winner_c(winner)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    next_state  = state;
    cnt_n       = cnt;
    gnt_port_n  = gnt_port;
    gnt_we_n    = gnt_we;
    ram_addr_n  = ram_addr_o;
    ram_wdata_n = ram_wdata_o;
    ram_we_n    = 1'b0;
    ram_wstrb_n = '0;
    if_ack_n    = 1'b0;
    if_err_n    = 1'b0;
    d_ack_n     = 1'b0;
    if_rdata_n  = if_rdata_o;
    d_rdata_n   = d_rdata_o;

    case (state)
      ARB_IDLE: begin
        if (if_req_i || d_req_i) begin
          gnt_port_n = winner;
          if (winner == PORT_D) begin
            ram_addr_n  = d_addr_i;
            ram_wdata_n = d_wdata_i;
            ram_we_n    = d_we_i;
            ram_wstrb_n = d_we_i ? d_wstrb_i : '0;
            gnt_we_n    = d_we_i;
            next_state  = ARB_ISSUE;
          end else if (if_addr_i[1:0] != 2'b00) begin
            // Misaligned fetch: answer with an error, RAM pins untouched.
            gnt_we_n   = 1'b0;
            if_ack_n   = 1'b1;
            if_err_n   = 1'b1;
            next_state = ARB_RESP;
          end else begin
            ram_addr_n = if_addr_i;
            gnt_we_n   = 1'b0;
            next_state = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        if (gnt_we) begin
          d_ack_n    = 1'b1;
          next_state = ARB_RESP;
        end else begin
          cnt_n      = CNT_W'(READ_LAT);
          next_state = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          if (gnt_port == PORT_IF) begin
            if_rdata_n = ram_rdata_i;
            if_ack_n   = 1'b1;
          end else begin
            d_rdata_n = ram_rdata_i;
            d_ack_n   = 1'b1;
          end
          next_state = ARB_RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase

    busy_n = (next_state != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      gnt_port    <= PORT_IF;
      gnt_we      <= 1'b0;
      if_ack_o    <= 1'b0;
      if_err_o    <= 1'b0;
      if_rdata_o  <= '0;
      d_ack_o     <= 1'b0;
      d_rdata_o   <= '0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_wstrb_o <= '0;
      ram_wdata_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_n;
      gnt_port    <= gnt_port_n;
      gnt_we      <= gnt_we_n;
      if_ack_o    <= if_ack_n;
      if_err_o    <= if_err_n;
      if_rdata_o  <= if_rdata_n;
      d_ack_o     <= d_ack_n;
      d_rdata_o   <= d_rdata_n;
      ram_addr_o  <= ram_addr_n;
      ram_we_o    <= ram_we_n;
      ram_wstrb_o <= ram_wstrb_n;
      ram_wdata_o <= ram_wdata_n;
      busy_o      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with READ_LAT=1/round-robin, one with READ_LAT=3/data priority.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  logic        a_if_req, a_if_ack, a_if_err, a_d_req, a_d_we, a_d_ack, a_ram_we, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_d_wstrb, a_ram_wstrb;

  logic        b_if_req, b_if_ack, b_if_err, b_d_req, b_d_we, b_d_ack, b_ram_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_d_wstrb, b_ram_wstrb;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .DATA_PRIORITY(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack), .if_err_o(a_if_err),
    .if_rdata_o(a_if_rdata), .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr),
    .d_wdata_i(a_d_wdata), .d_wstrb_i(a_d_wstrb), .d_ack_o(a_d_ack), .d_rdata_o(a_d_rdata),
    .ram_addr_o(a_ram_addr), .ram_we_o(a_ram_we), .ram_wstrb_o(a_ram_wstrb),
    .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata), .busy_o(a_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .DATA_PRIORITY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack), .if_err_o(b_if_err),
    .if_rdata_o(b_if_rdata), .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr),
    .d_wdata_i(b_d_wdata), .d_wstrb_i(b_d_wstrb), .d_ack_o(b_d_ack), .d_rdata_o(b_d_rdata),
    .ram_addr_o(b_ram_addr), .ram_we_o(b_ram_we), .ram_wstrb_o(b_ram_wstrb),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata), .busy_o(b_busy)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return {8'hA5, 8'(i), 8'h5A, 8'(i)};
  endfunction

  // RAM A: latency 1, reloaded with the init pattern on every reset.
  logic [31:0] mem_a [0:63];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
      a_ram_rdata <= '0;
    end else begin
      if (a_ram_we)
        for (int k = 0; k < 4; k++)
          if (a_ram_wstrb[k]) mem_a[a_ram_addr[7:2]][8*k +: 8] <= a_ram_wdata[8*k +: 8];
      a_ram_rdata <= mem_a[a_ram_addr[7:2]];
    end
  end

  // RAM B: latency 3 read pipeline.
  logic [31:0] mem_b [0:63];
  logic [31:0] b_p0, b_p1, b_p2;
  assign b_ram_rdata = b_p2;
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= init_word(i);
      b_p0 <= '0; b_p1 <= '0; b_p2 <= '0;
    end else begin
      if (b_ram_we)
        for (int k = 0; k < 4; k++)
          if (b_ram_wstrb[k]) mem_b[b_ram_addr[7:2]][8*k +: 8] <= b_ram_wdata[8*k +: 8];
      b_p0 <= mem_b[b_ram_addr[7:2]];
      b_p1 <= b_p0;
      b_p2 <= b_p1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_cnt++; if (a_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_a_busy: got %b expected 0", a_busy); end
    vec_cnt++; if ({a_if_ack, a_d_ack, a_if_err} !== 3'b000) begin err_cnt++; $display("FAIL reset_a_acks: got %b expected 000", {a_if_ack, a_d_ack, a_if_err}); end
    vec_cnt++; if ({a_ram_we, a_ram_wstrb} !== 5'b0) begin err_cnt++; $display("FAIL reset_a_we: got %b expected 00000", {a_ram_we, a_ram_wstrb}); end
    vec_cnt++; if (a_ram_addr !== 32'h0) begin err_cnt++; $display("FAIL reset_a_addr: got %h expected 0", a_ram_addr); end
    vec_cnt++; if ({a_if_rdata, a_d_rdata} !== 64'h0) begin err_cnt++; $display("FAIL reset_a_rdata: got %h expected 0", {a_if_rdata, a_d_rdata}); end
    vec_cnt++; if ({b_busy, b_if_ack, b_d_ack, b_ram_we} !== 4'b0) begin err_cnt++; $display("FAIL reset_b_ctl: got %b expected 0000", {b_busy, b_if_ack, b_d_ack, b_ram_we}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    a_if_addr = 32'h10; a_if_req = 1'b1;
    tick();
    vec_cnt++; if (a_ram_addr !== 32'h10) begin err_cnt++; $display("FAIL fetch_issue_addr: got %h expected 00000010", a_ram_addr); end
    vec_cnt++; if ({a_busy, a_ram_we, a_if_ack} !== 3'b100) begin err_cnt++; $display("FAIL fetch_issue_ctl: got %b expected 100", {a_busy, a_ram_we, a_if_ack}); end
    tick();
    vec_cnt++; if (a_if_ack !== 1'b0) begin err_cnt++; $display("FAIL fetch_wait_ack: got %b expected 0", a_if_ack); end
    tick();
    vec_cnt++; if ({a_if_ack, a_if_err, a_d_ack} !== 3'b100) begin err_cnt++; $display("FAIL fetch_ack: got %b expected 100", {a_if_ack, a_if_err, a_d_ack}); end
    vec_cnt++; if (a_if_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL fetch_rdata: got %h expected deadbeef", a_if_rdata); end
    a_if_req = 1'b0;
    tick();
    vec_cnt++; if ({a_if_ack, a_busy} !== 2'b00) begin err_cnt++; $display("FAIL fetch_done: got %b expected 00", {a_if_ack, a_busy}); end
  endtask

  task automatic test_store_load();
    a_d_we = 1'b1; a_d_addr = 32'h20; a_d_wdata = 32'h11223344; a_d_wstrb = 4'b0011; a_d_req = 1'b1;
    tick();
    vec_cnt++; if ({a_ram_we, a_ram_wstrb} !== 5'b10011) begin err_cnt++; $display("FAIL store_we: got %b expected 10011", {a_ram_we, a_ram_wstrb}); end
    vec_cnt++; if ({a_ram_addr, a_ram_wdata} !== {32'h20, 32'h11223344}) begin err_cnt++; $display("FAIL store_bus: got %h expected 0000002011223344", {a_ram_addr, a_ram_wdata}); end
    vec_cnt++; if (a_d_ack !== 1'b0) begin err_cnt++; $display("FAIL store_early_ack: got %b expected 0", a_d_ack); end
    tick();
    vec_cnt++; if ({a_ram_we, a_ram_wstrb, a_d_ack} !== 6'b000001) begin err_cnt++; $display("FAIL store_ack: got %b expected 000001", {a_ram_we, a_ram_wstrb, a_d_ack}); end
    a_d_req = 1'b0; a_d_we = 1'b0; a_d_wstrb = 4'b0;
    tick();
    vec_cnt++; if ({a_d_ack, a_busy} !== 2'b00) begin err_cnt++; $display("FAIL store_done: got %b expected 00", {a_d_ack, a_busy}); end
    a_d_req = 1'b1;
    tick();
    vec_cnt++; if (a_ram_we !== 1'b0) begin err_cnt++; $display("FAIL load_we: got %b expected 0", a_ram_we); end
    tick();
    tick();
    vec_cnt++; if ({a_d_ack, a_if_ack} !== 2'b10) begin err_cnt++; $display("FAIL load_ack: got %b expected 10", {a_d_ack, a_if_ack}); end
    vec_cnt++; if (a_d_rdata !== 32'hA5083344) begin err_cnt++; $display("FAIL load_rdata: got %h expected a5083344", a_d_rdata); end
    vec_cnt++; if (a_if_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL load_if_rdata_kept: got %h expected deadbeef", a_if_rdata); end
    a_d_req = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    a_if_addr = 32'h13; a_if_req = 1'b1;
    tick();
    vec_cnt++; if ({a_if_ack, a_if_err, a_ram_we, a_busy} !== 4'b1101) begin err_cnt++; $display("FAIL misal_ack: got %b expected 1101", {a_if_ack, a_if_err, a_ram_we, a_busy}); end
    vec_cnt++; if (a_ram_addr !== 32'h20) begin err_cnt++; $display("FAIL misal_addr_kept: got %h expected 00000020", a_ram_addr); end
    vec_cnt++; if (a_if_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL misal_rdata_kept: got %h expected deadbeef", a_if_rdata); end
    a_if_req = 1'b0;
    tick();
    vec_cnt++; if ({a_if_ack, a_if_err, a_busy} !== 3'b000) begin err_cnt++; $display("FAIL misal_done: got %b expected 000", {a_if_ack, a_if_err, a_busy}); end
  endtask

  task automatic test_contention();
    int  n;
    logic seq [0:3];
    logic prev_if, prev_d;
    n = 0; prev_if = 1'b0; prev_d = 1'b0;
    reset = 1'b0;
    a_if_addr = 32'h10; a_if_req = 1'b1;
    a_d_addr = 32'h20; a_d_we = 1'b0; a_d_req = 1'b1;
    tick(); tick();
    reset = 1'b1;
    for (int c = 0; c < 24 && n < 4; c++) begin
      tick();
      vec_cnt++; if (a_if_ack && a_d_ack) begin err_cnt++; $display("FAIL rr_overlap: got both acks at cycle %0d expected one", c); end
      vec_cnt++; if ((a_if_ack && prev_if) || (a_d_ack && prev_d)) begin err_cnt++; $display("FAIL rr_double_pulse: got 2-cycle ack at cycle %0d expected 1", c); end
      if (a_if_ack) begin
        seq[n] = 1'b0; n++;
        vec_cnt++; if (a_if_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rr_if_rdata: got %h expected deadbeef", a_if_rdata); end
      end else if (a_d_ack) begin
        seq[n] = 1'b1; n++;
        vec_cnt++; if (a_d_rdata !== 32'hA5085A08) begin err_cnt++; $display("FAIL rr_d_rdata: got %h expected a5085a08", a_d_rdata); end
      end
      prev_if = a_if_ack; prev_d = a_d_ack;
    end
    vec_cnt++; if (n !== 4) begin err_cnt++; $display("FAIL rr_ack_count: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      vec_cnt++; if (seq[i] !== 1'(i % 2)) begin err_cnt++; $display("FAIL rr_order: got port %0d at grant %0d expected %0d", seq[i], i, i % 2); end
    end
    a_if_req = 1'b0; a_d_req = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_data_priority();
    int d_acks, i_acks;
    bit got_if;
    d_acks = 0; i_acks = 0; got_if = 1'b0;
    b_if_addr = 32'h10; b_if_req = 1'b1;
    b_d_addr = 32'h24; b_d_we = 1'b0; b_d_req = 1'b1;
    for (int c = 0; c < 27; c++) begin
      tick();
      if (b_if_ack) i_acks++;
      if (b_d_ack) begin
        d_acks++;
        vec_cnt++; if (b_d_rdata !== 32'hA5095A09) begin err_cnt++; $display("FAIL prio_d_rdata: got %h expected a5095a09", b_d_rdata); end
      end
    end
    vec_cnt++; if (i_acks !== 0) begin err_cnt++; $display("FAIL prio_if_starved: got %0d fetch acks expected 0", i_acks); end
    vec_cnt++; if (d_acks !== 4) begin err_cnt++; $display("FAIL prio_d_count: got %0d expected 4", d_acks); end
    // Dropping d_req mid-transaction: that load still acks, then fetch is served.
    b_d_req = 1'b0;
    d_acks = 0;
    for (int c = 0; c < 20 && !got_if; c++) begin
      tick();
      if (b_d_ack) d_acks++;
      if (b_if_ack) got_if = 1'b1;
    end
    vec_cnt++; if (d_acks !== 1) begin err_cnt++; $display("FAIL prio_dropped_req_ack: got %0d expected 1", d_acks); end
    vec_cnt++; if (got_if !== 1'b1) begin err_cnt++; $display("FAIL prio_if_timeout: got no fetch ack expected 1"); end
    vec_cnt++; if (b_if_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL prio_if_rdata: got %h expected deadbeef", b_if_rdata); end
    b_if_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    b_if_addr = 32'h10; b_if_req = 1'b1;
    tick(); tick(); tick();
    vec_cnt++; if ({b_busy, b_if_ack} !== 2'b10) begin err_cnt++; $display("FAIL rst_mid_wait: got %b expected 10", {b_busy, b_if_ack}); end
    reset = 1'b0;
    tick();
    vec_cnt++; if ({b_busy, b_if_ack, b_ram_we} !== 3'b000) begin err_cnt++; $display("FAIL rst_mid_ctl: got %b expected 000", {b_busy, b_if_ack, b_ram_we}); end
    vec_cnt++; if ({b_ram_addr, b_if_rdata} !== 64'h0) begin err_cnt++; $display("FAIL rst_mid_regs: got %h expected 0", {b_ram_addr, b_if_rdata}); end
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vec_cnt++; if (b_if_ack !== 1'(k == 5)) begin err_cnt++; $display("FAIL rst_refetch_ack: got %b at cycle %0d expected %b", b_if_ack, k, (k == 5)); end
    end
    vec_cnt++; if (b_if_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rst_refetch_rdata: got %h expected deadbeef", b_if_rdata); end
    b_if_req = 1'b0;
    tick();
    vec_cnt++; if ({b_busy, b_if_ack} !== 2'b00) begin err_cnt++; $display("FAIL rst_refetch_done: got %b expected 00", {b_busy, b_if_ack}); end
  endtask

  initial begin
    reset = 1'b0;
    a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = '0; a_d_wdata = '0; a_d_wstrb = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = '0; b_d_wdata = '0; b_d_wstrb = '0;
    tick(); tick(); tick();
    test_reset();
    test_fetch();
    test_store_load();
    test_misaligned();
    test_contention();
    test_data_priority();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
